ibus_mem32: RTL
===============

// Module: ibus_mem32
// PURPOSE
// - Instruction-bus responder: the memory end of the ireq/irsp interface driven by the prefetch unit.
// - Accepts word fetches on ireqvalid/ireqready and returns data from an internal word RAM.
// - Returns every accepted request exactly once, in order, with irsprerr flagging range and privilege faults.
// - Backdoor load port fills the RAM for boot and test.
// PARAMETERS
// - C_ADDR_WIDTH_X  10     RAM holds 2^C_ADDR_WIDTH_X 32-bit words.
// - C_BASE_ADDR     32'b0  byte address of word 0; must be aligned to the window size.
// - C_USER_BASE     32'b0  fetches below this address with hpl == `RV_HPL_USER fault.
// - C_READ_LATENCY  2      cycles from request acceptance to response valid, no backpressure; >= 2.
// - C_FIFO_DEPTH_X  2      response buffer depth 2^C_FIFO_DEPTH_X; 2^C_FIFO_DEPTH_X >= C_READ_LATENCY.
// PORTS
// - clk_i        in   1   clock.
// - resetb_i     in   1   async reset, active low.
// - clk_en_i     in   1   global clock enable; when low all state holds and no handshake completes.
// - ireqready_o  out  1   request may be accepted this cycle.
// - ireqvalid_i  in   1   request valid.
// - ireqhpl_i    in   2   privilege level of the request.
// - ireqaddr_i   in   32  byte address; bits [1:0] ignored.
// - irspready_i  in   1   requester can take a response.
// - irspvalid_o  out  1   response valid.
// - irsprerr_o   out  1   response is a fetch fault.
// - irspdata_o   out  32  fetched word; 32'b0 when irsprerr_o is high.
// - ld_wr_i      in   1   backdoor write strobe.
// - ld_addr_i    in   C_ADDR_WIDTH_X  backdoor word index.
// - ld_data_i    in   32  backdoor write data.
// BEHAVIOUR
// - Clock clk_i, single domain; reset asynchronous, active low (resetb_i); reset sets irspvalid_o=0, ireqready_o=1, irsprerr_o=0, irspdata_o=0 and clears credits, pipeline and buffer. RAM contents are not reset.
// - Accept = ireqvalid_i & ireqready_o & clk_en_i; response transfer = irspvalid_o & irspready_i & clk_en_i.
// - Credit counter (C_FIFO_DEPTH_X+1 bits) = requests in pipeline + entries in buffer; +1 on accept, -1 on transfer, unchanged on both.
// - ireqready_o = credits < 2^C_FIFO_DEPTH_X, registered-free (combinational from counter only, never from ireqvalid_i).
// - A transfer frees a credit the following cycle, not the same cycle; no overflow under any irspready_i pattern.
// - Fault: addr outside [C_BASE_ADDR, C_BASE_ADDR + 4*2^C_ADDR_WIDTH_X), or hpl == `RV_HPL_USER and addr < C_USER_BASE; fault decided at accept, carried with the request.
// - Faulted requests still occupy one credit and return in order; RAM read suppressed.
// - Latency: accept at edge N -> irspvalid_o high after edge N+C_READ_LATENCY-1 when buffer empty; held with stable data/rerr until transferred.
// - Back-to-back accepts sustain one response per cycle while irspready_i stays high.
// - Backdoor write and read to the same word in one cycle: read returns old data (read-before-write); ld_wr_i ignored when clk_en_i low.
// - No flush input: a requester discarding after vectoring still consumes every response.
// - Reset mid-flight: all in-flight requests dropped, no response issued for them.
// STRUCTURE
// - Shared riscv_defs.v: `RV_HPL_USER (2'b00) and the HPL width define; no local copies.
// - Response buffer: existing fifo module (C_FIFO_WIDTH 33 = {rerr, data}, flush tied low).
// - One sub-module: ibus_mem32_ram, 1-read/1-write synchronous word RAM, 1-cycle read.
// - Top level: fault decode, delay pipeline of (valid, rerr) for C_READ_LATENCY-2 stages, credit counter.
// TESTING
// - Preload word index 0x40 = 32'hDEADBEEF; fetch 0x100, hpl 2'b11 -> irspvalid after 2 cycles, data DEADBEEF, rerr 0.
// - Fetch 0x102 -> same word DEADBEEF (low bits ignored); stream 0x100..0x10C back to back -> 4 responses, 1 per cycle, in order.
// - Fetch 0x1000 with C_ADDR_WIDTH_X 10 -> rerr 1, data 0; fetch 0x20 hpl 2'b00 with C_USER_BASE 0x80 -> rerr 1; same with hpl 2'b11 -> rerr 0.
// - irspready_i low 10 cycles while ireqvalid_i held -> exactly 4 accepts (C_FIFO_DEPTH_X 2), ireqready_o low; release -> all data in order, none lost or duplicated.
// - clk_en_i low mid-stream 5 cycles -> no accepts, outputs frozen; resume -> latency counted in enabled cycles only.
// - resetb_i pulsed with 3 in flight -> irspvalid_o 0 immediately, ireqready_o 1, credits 0; RAM preload still readable.

Source files
------------

// File: rtl/ibus_mem32_pkg.sv
// ibus_mem32_pkg: shared privilege encoding, response record and fetch fault decode
package ibus_mem32_pkg;

   localparam int         RV_HPL_W    = 2;
   localparam logic [1:0] RV_HPL_USER = 2'b00;

   typedef struct packed {
      logic        rerr;
      logic [31:0] data;
   } rsp_t;

   // Borrow out of the 33-bit subtraction marks addresses below the base.
   function automatic logic fetch_fault(input logic [31:0] addr, input logic [RV_HPL_W-1:0] hpl,
                                        input logic [31:0] base, input logic [31:0] user_base,
                                        input int aw);
      logic [32:0] off;
      off = {1'b0, addr} - {1'b0, base};
      return off[32] | (off >= (33'd1 << (aw + 2))) | ((hpl == RV_HPL_USER) & (addr < user_base));
   endfunction

endpackage

// File: rtl/fifo.sv
// fifo: first-word-fall-through synchronous FIFO
//   clk_i, resetb_i : clock, async active-low reset
//   flush_i         : synchronous clear of both pointers
//   wr_i / wdata_i  : push
//   rd_i / rdata_o  : pop / head entry (valid while empty_o is low)
//   empty_o         : no entries
module fifo #(
   parameter int C_FIFO_WIDTH   = 33,
   parameter int C_FIFO_DEPTH_X = 2
) (
   input  logic                    clk_i,
   input  logic                    resetb_i,
   input  logic                    flush_i,
   input  logic                    wr_i,
   input  logic [C_FIFO_WIDTH-1:0] wdata_i,
   input  logic                    rd_i,
   output logic [C_FIFO_WIDTH-1:0] rdata_o,
   output logic                    empty_o
);

   logic [C_FIFO_WIDTH-1:0] mem [2**C_FIFO_DEPTH_X];
   logic [C_FIFO_DEPTH_X:0] wp_q, wp_d, rp_q, rp_d;

   always_comb begin
      wp_d = flush_i ? '0 : wp_q + (C_FIFO_DEPTH_X+1)'(wr_i);
      rp_d = flush_i ? '0 : rp_q + (C_FIFO_DEPTH_X+1)'(rd_i);
   end

   always_ff @(posedge clk_i or negedge resetb_i)
      if (!resetb_i) begin
         wp_q <= '0;
         rp_q <= '0;
      end else begin
         wp_q <= wp_d;
         rp_q <= rp_d;
      end

   always_ff @(posedge clk_i)
      if (wr_i) mem[wp_q[C_FIFO_DEPTH_X-1:0]] <= wdata_i;

   assign rdata_o = mem[rp_q[C_FIFO_DEPTH_X-1:0]];
   assign empty_o = wp_q == rp_q;

endmodule

// File: rtl/ibus_mem32_ram.sv
// ibus_mem32_ram: 1-read/1-write synchronous word RAM, one-cycle read, read-before-write
//   clk_i            : clock
//   en_i             : clock enable for both ports
//   re_i, raddr_i    : read strobe and word index; rdata_o valid the cycle after
//   we_i, waddr_i, wdata_i : write port
module ibus_mem32_ram #(
   parameter int C_ADDR_WIDTH_X = 10
) (
   input  logic                      clk_i,
   input  logic                      en_i,
   input  logic                      re_i,
   input  logic [C_ADDR_WIDTH_X-1:0] raddr_i,
   output logic [31:0]               rdata_o,
   input  logic                      we_i,
   input  logic [C_ADDR_WIDTH_X-1:0] waddr_i,
   input  logic [31:0]               wdata_i
);

   logic [31:0] mem [2**C_ADDR_WIDTH_X];
   logic [31:0] rdata_q;

   // Both ports sampled on the same edge: a colliding read sees the old word.
   always_ff @(posedge clk_i)
      if (en_i) begin
         if (re_i) rdata_q <= mem[raddr_i];
         if (we_i) mem[waddr_i] <= wdata_i;
      end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/ibus_mem32.sv
// ibus_mem32: instruction-bus responder returning in-order word fetches from an internal RAM
//   clk_i, resetb_i, clk_en_i           : clock, async active-low reset, global enable
//   ireqvalid_i/ireqready_o, ireqhpl_i, ireqaddr_i : fetch request channel
//   irspvalid_o/irspready_i, irsprerr_o, irspdata_o : response channel
//   ld_wr_i, ld_addr_i, ld_data_i       : backdoor RAM load
module ibus_mem32
   import ibus_mem32_pkg::*;
#(
   parameter int          C_ADDR_WIDTH_X = 10,
   parameter logic [31:0] C_BASE_ADDR    = 32'h0,
   parameter logic [31:0] C_USER_BASE    = 32'h0,
   parameter int          C_READ_LATENCY = 2,
   parameter int          C_FIFO_DEPTH_X = 2
) (
   input  logic                      clk_i,
   input  logic                      resetb_i,
   input  logic                      clk_en_i,
   output logic                      ireqready_o,
   input  logic                      ireqvalid_i,
   input  logic [RV_HPL_W-1:0]       ireqhpl_i,
   input  logic [31:0]               ireqaddr_i,
   input  logic                      irspready_i,
   output logic                      irspvalid_o,
   output logic                      irsprerr_o,
   output logic [31:0]               irspdata_o,
   input  logic                      ld_wr_i,
   input  logic [C_ADDR_WIDTH_X-1:0] ld_addr_i,
   input  logic [31:0]               ld_data_i
);

   localparam int CW = C_FIFO_DEPTH_X + 1;

   logic                      acc, xfer, flt, empty;
   logic [31:0]               waddr, ram_rdata;
   logic [C_ADDR_WIDTH_X-1:0] idx;
   logic [CW-1:0]             credits_q, credits_d;
   logic                      tv, te;
   logic [C_ADDR_WIDTH_X-1:0] ta;
   logic                      rd_v_q, rd_v_d, rd_e_q, rd_e_d;
   rsp_t                      rsp, fo;

   assign waddr       = ireqaddr_i & 32'hFFFF_FFFC;
   assign idx         = C_ADDR_WIDTH_X'((waddr - C_BASE_ADDR) >> 2);
   assign flt         = fetch_fault(waddr, ireqhpl_i, C_BASE_ADDR, C_USER_BASE, C_ADDR_WIDTH_X);
   // Credits count every request between acceptance and transfer, so the buffer can never overflow.
   assign ireqready_o = credits_q < CW'(2**C_FIFO_DEPTH_X);
   assign acc         = ireqvalid_i & ireqready_o & clk_en_i;
   assign irspvalid_o = ~empty;
   assign xfer        = irspvalid_o & irspready_i & clk_en_i;

   // (tv, te, ta) is the request as it reaches the RAM read port, C_READ_LATENCY-2 cycles after accept.
   if (C_READ_LATENCY == 2) begin : g_nopipe
      assign tv = acc;
      assign te = acc & flt;
      assign ta = idx;
   end else begin : g_pipe
      localparam int NS = C_READ_LATENCY - 2;
      logic [NS-1:0]             pv_q, pe_q;
      logic [C_ADDR_WIDTH_X-1:0] pa_q [NS];
      always_ff @(posedge clk_i or negedge resetb_i)
         if (!resetb_i) begin
            pv_q <= '0;
            pe_q <= '0;
         end else if (clk_en_i) begin
            pv_q <= (pv_q << 1) | NS'(acc);
            pe_q <= (pe_q << 1) | NS'(acc & flt);
         end
      always_ff @(posedge clk_i)
         if (clk_en_i) begin
            pa_q[0] <= idx;
            for (int i = 1; i < NS; i++) pa_q[i] <= pa_q[i-1];
         end
      assign tv = pv_q[NS-1];
      assign te = pe_q[NS-1];
      assign ta = pa_q[NS-1];
   end

   always_comb begin
      credits_d = (acc & ~xfer) ? credits_q + CW'(1) : (~acc & xfer) ? credits_q - CW'(1) : credits_q;
      rd_v_d    = clk_en_i ? tv : rd_v_q;
      rd_e_d    = clk_en_i ? te : rd_e_q;
      rsp.rerr  = rd_e_q;
      rsp.data  = rd_e_q ? 32'h0 : ram_rdata;
   end

   always_ff @(posedge clk_i or negedge resetb_i)
      if (!resetb_i) begin
         credits_q <= '0;
         rd_v_q    <= 1'b0;
         rd_e_q    <= 1'b0;
      end else begin
         credits_q <= credits_d;
         rd_v_q    <= rd_v_d;
         rd_e_q    <= rd_e_d;
      end

   // Faulted requests skip the RAM read but still flow through to the buffer.
   ibus_mem32_ram #(.C_ADDR_WIDTH_X(C_ADDR_WIDTH_X)) u_ram (
      .clk_i   (clk_i),
      .en_i    (clk_en_i),
      .re_i    (tv & ~te),
      .raddr_i (ta),
      .rdata_o (ram_rdata),
      .we_i    (ld_wr_i),
      .waddr_i (ld_addr_i),
      .wdata_i (ld_data_i)
   );

   fifo #(.C_FIFO_WIDTH(33), .C_FIFO_DEPTH_X(C_FIFO_DEPTH_X)) u_fifo (
      .clk_i    (clk_i),
      .resetb_i (resetb_i),
      .flush_i  (1'b0),
      .wr_i     (rd_v_q & clk_en_i),
      .wdata_i  (rsp),
      .rd_i     (xfer),
      .rdata_o  (fo),
      .empty_o  (empty)
   );

   assign irsprerr_o = ~empty & fo.rerr;
   assign irspdata_o = empty ? 32'h0 : fo.data;

endmodule
